gate_drive_if: RTL and testbench

- Driver-side end of the enable/status interface produced by the pulse-logic block.
- Consumes IGBT_on_EN[4:0] and SCR_on_EN[1:0].
- Drives the physical IGBT gates with dead-time interlock and an on-time watchdog, and drives the SCR gates with trigger pulse trains.
- Returns IGBT_status, SCR_status, and per-board fault/error flags; accepts per-board fault-reset requests.
- Board mapping: board1 = IGBT0/IGBT1, board2 = IGBT2/IGBT3, board3 = IGBT4 (single channel, no partner).

---
 rtl/gate_drive_pkg.sv | 48 ++++
 rtl/gate_drive_if_igbt_channel_fsm.sv | 84 ++++++++
 rtl/gate_drive_if.sv | 194 +++++++++++++++++++
 tb/tb_gate_drive_if.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_drive_pkg.sv
// Shared types and board mapping for the gate driver interface.
package gate_drive_pkg;

    localparam int unsigned NumIgbt  = 5;
    localparam int unsigned NumScr   = 2;
    localparam int unsigned NumBoard = 3;

    // Watchdog counter width, wide enough for the 100 ms default limit.
    localparam int unsigned OnCntW = 24;

    // Marks a channel that has no partner (IGBT4 on board3).
    localparam int NoPartner = -1;

    typedef enum logic [1:0] {
        IgbtOff,
        IgbtArm,
        IgbtOn,
        IgbtLock
    } igbt_state_e;

    typedef enum logic [1:0] {
        ScrIdle,
        ScrHi,
        ScrLo
    } scr_state_e;

    // PARTNER = {1, 0, 3, 2, none}
    function automatic int partner_of(input int unsigned ch);
        case (ch)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            3:       return 2;
            default: return NoPartner;
        endcase
    endfunction

    // BOARD = {0, 0, 1, 1, 2}
    function automatic int unsigned board_of(input int unsigned ch);
        return ch / 2;
    endfunction

    // Counter width able to hold n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_drive_if_igbt_channel_fsm.sv
// Single IGBT channel: dead-time interlock against the partner gate and an
// on-time watchdog. The gate output is a registered decode of the ON state.
module igbt_channel_fsm
    import gate_drive_pkg::*;
#(
    parameter int unsigned DEAD_CYC   = 100,
    parameter int unsigned MAX_ON_CYC = 5_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en_i,
    input  logic block_i,
    input  logic partner_gate_i,
    output logic gate_o
);

    localparam int unsigned DeadW = cnt_width(DEAD_CYC);
    localparam logic [DeadW-1:0]  DeadLast = DeadW'(DEAD_CYC - 1);
    localparam logic [OnCntW-1:0] OnLast   = OnCntW'(MAX_ON_CYC - 1);

    igbt_state_e       state_q;
    logic [DeadW-1:0]  dead_cnt_q;
    logic [OnCntW-1:0] on_cnt_q;
    logic              gate_q;

    // Channel FSM with its dead-time and watchdog counters and the registered gate.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IgbtOff;
            dead_cnt_q <= '0;
            on_cnt_q   <= '0;
            gate_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IgbtOff: begin
                    if (en_i && !block_i) begin
                        state_q    <= IgbtArm;
                        dead_cnt_q <= '0;
                    end
                end
                IgbtArm: begin
                    if (!en_i) begin
                        state_q <= IgbtOff;
                    end else if (block_i) begin
                        state_q <= IgbtLock;
                    end else if (partner_gate_i) begin
                        // Dead time only starts once the partner is actually low.
                        dead_cnt_q <= '0;
                    end else if (dead_cnt_q == DeadLast) begin
                        state_q  <= IgbtOn;
                        on_cnt_q <= '0;
                        gate_q   <= 1'b1;
                    end else begin
                        dead_cnt_q <= dead_cnt_q + 1'b1;
                    end
                end
                IgbtOn: begin
                    if (!en_i) begin
                        state_q <= IgbtOff;
                        gate_q  <= 1'b0;
                    end else if (block_i || on_cnt_q == OnLast) begin
                        state_q <= IgbtLock;
                        gate_q  <= 1'b0;
                    end else if (on_cnt_q != '1) begin
                        on_cnt_q <= on_cnt_q + 1'b1;
                    end
                end
                IgbtLock: begin
                    // Restart requires the request to be withdrawn first.
                    if (!en_i) begin
                        state_q <= IgbtOff;
                    end
                end
                default: begin
                    state_q <= IgbtOff;
                    gate_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gate_o = gate_q;

endmodule

// File: rtl/gate_drive_if.sv
// Driver-side end of the pulse-logic enable/status interface: five interlocked
// IGBT channels, two SCR trigger trains and per-board fault filtering.
module gate_drive_if
    import gate_drive_pkg::*;
#(
    parameter int unsigned DEAD_CYC     = 100,
    parameter int unsigned MAX_ON_CYC   = 5_000_000,
    parameter int unsigned FLT_FILT_CYC = 25,
    parameter int unsigned SCR_HI_CYC   = 500,
    parameter int unsigned SCR_LO_CYC   = 1500
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NumIgbt-1:0]  IGBT_on_EN,
    input  logic [NumScr-1:0]   SCR_on_EN,
    input  logic                reset_IGBT_driver1,
    input  logic                reset_IGBT_driver2,
    input  logic                reset_IGBT_driver3,
    input  logic [NumBoard-1:0] drv_fault_n,
    output logic [NumIgbt-1:0]  igbt_gate,
    output logic [NumScr-1:0]   scr_gate,
    output logic [NumIgbt-1:0]  IGBT_status,
    output logic [NumScr-1:0]   SCR_status,
    output logic                fault_IGBT_driver1,
    output logic                fault_IGBT_driver2,
    output logic                fault_IGBT_driver3,
    output logic                error_IGBT_driver1,
    output logic                error_IGBT_driver2,
    output logic                error_IGBT_driver3
);

    localparam int unsigned FltW = cnt_width(FLT_FILT_CYC);
    localparam logic [FltW-1:0] FltLast = FltW'(FLT_FILT_CYC - 1);

    localparam int unsigned ScrMax = (SCR_HI_CYC > SCR_LO_CYC) ? SCR_HI_CYC : SCR_LO_CYC;
    localparam int unsigned ScrW   = cnt_width(ScrMax);
    localparam logic [ScrW-1:0] ScrHiLast = ScrW'(SCR_HI_CYC - 1);
    localparam logic [ScrW-1:0] ScrLoLast = ScrW'(SCR_LO_CYC - 1);

    logic [NumBoard-1:0] rst_req;
    logic [NumBoard-1:0] sync1_q;
    logic [NumBoard-1:0] sync2_q;
    logic [NumBoard-1:0][FltW-1:0] flt_cnt_q;
    logic [NumBoard-1:0] flt_q;
    logic [NumBoard-1:0] err_q;
    logic [NumIgbt-1:0]  gate_w;

    scr_state_e [NumScr-1:0]           scr_state_q;
    logic       [NumScr-1:0][ScrW-1:0] scr_cnt_q;
    logic       [NumScr-1:0]           scr_en_q;
    logic       [NumScr-1:0]           scr_gate_q;
    logic       [NumScr-1:0]           scr_status_q;

    assign rst_req = {reset_IGBT_driver3, reset_IGBT_driver2, reset_IGBT_driver1};

    // Double-flop synchroniser for the raw fault lines, idling at the no-fault level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= drv_fault_n;
            sync2_q <= sync1_q;
        end
    end

    // Fault filter and latch per board; clearing is only honoured once the fault is gone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flt_cnt_q <= '0;
            flt_q     <= '0;
        end else begin
            for (int b = 0; b < NumBoard; b++) begin
                if (!sync2_q[b]) begin
                    if (flt_cnt_q[b] == FltLast) begin
                        flt_q[b] <= 1'b1;
                    end else begin
                        flt_cnt_q[b] <= flt_cnt_q[b] + 1'b1;
                    end
                end else begin
                    flt_cnt_q[b] <= '0;
                    if (rst_req[b]) begin
                        flt_q[b] <= 1'b0;
                    end
                end
            end
        end
    end

    // Both-enables error per board, registered and not latched; board3 has no pair.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= {1'b0, IGBT_on_EN[3] & IGBT_on_EN[2], IGBT_on_EN[1] & IGBT_on_EN[0]};
        end
    end

    for (genvar i = 0; i < NumIgbt; i++) begin : g_igbt
        localparam int          Partner = partner_of(i);
        localparam int unsigned Board   = board_of(i);

        logic partner_gate;
        logic block;

        if (Partner != NoPartner) begin : g_pair
            assign partner_gate = gate_w[Partner];
        end else begin : g_solo
            assign partner_gate = 1'b0;
        end

        assign block = flt_q[Board] | err_q[Board];

        igbt_channel_fsm #(
            .DEAD_CYC   (DEAD_CYC),
            .MAX_ON_CYC (MAX_ON_CYC)
        ) u_fsm (
            .sys_clk        (sys_clk),
            .sys_rst_n      (sys_rst_n),
            .en_i           (IGBT_on_EN[i]),
            .block_i        (block),
            .partner_gate_i (partner_gate),
            .gate_o         (gate_w[i])
        );
    end

    // SCR trigger trains: a started HI pulse always runs to completion, LO aborts on en low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int s = 0; s < NumScr; s++) begin
                scr_state_q[s] <= ScrIdle;
            end
            scr_cnt_q    <= '0;
            scr_en_q     <= '0;
            scr_gate_q   <= '0;
            scr_status_q <= '0;
        end else begin
            for (int s = 0; s < NumScr; s++) begin
                scr_en_q[s] <= SCR_on_EN[s];
                unique case (scr_state_q[s])
                    ScrIdle: begin
                        if (SCR_on_EN[s] && !scr_en_q[s]) begin
                            scr_state_q[s]  <= ScrHi;
                            scr_cnt_q[s]    <= '0;
                            scr_gate_q[s]   <= 1'b1;
                            scr_status_q[s] <= 1'b1;
                        end
                    end
                    ScrHi: begin
                        if (scr_cnt_q[s] == ScrHiLast) begin
                            scr_state_q[s] <= ScrLo;
                            scr_cnt_q[s]   <= '0;
                            scr_gate_q[s]  <= 1'b0;
                        end else begin
                            scr_cnt_q[s] <= scr_cnt_q[s] + 1'b1;
                        end
                    end
                    ScrLo: begin
                        if (!SCR_on_EN[s]) begin
                            scr_state_q[s]  <= ScrIdle;
                            scr_cnt_q[s]    <= '0;
                            scr_status_q[s] <= 1'b0;
                        end else if (scr_cnt_q[s] == ScrLoLast) begin
                            scr_state_q[s] <= ScrHi;
                            scr_cnt_q[s]   <= '0;
                            scr_gate_q[s]  <= 1'b1;
                        end else begin
                            scr_cnt_q[s] <= scr_cnt_q[s] + 1'b1;
                        end
                    end
                    default: begin
                        scr_state_q[s]  <= ScrIdle;
                        scr_cnt_q[s]    <= '0;
                        scr_gate_q[s]   <= 1'b0;
                        scr_status_q[s] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign igbt_gate   = gate_w;
    assign IGBT_status = gate_w;
    assign scr_gate    = scr_gate_q;
    assign SCR_status  = scr_status_q;

    assign fault_IGBT_driver1 = flt_q[0];
    assign fault_IGBT_driver2 = flt_q[1];
    assign fault_IGBT_driver3 = flt_q[2];
    assign error_IGBT_driver1 = err_q[0];
    assign error_IGBT_driver2 = err_q[1];
    assign error_IGBT_driver3 = err_q[2];

endmodule

// File: tb/tb_gate_drive_if.sv
// Randomised and directed bench for gate_drive_if against a cycle-level reference model.
module tb_gate_drive_if;

    localparam int DEAD  = 100;
    localparam int MAXON = 1000;
    localparam int FLT   = 25;
    localparam int HI    = 500;
    localparam int LO    = 1500;
    localparam int PER   = HI + LO;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [4:0] IGBT_on_EN = '0;
    logic [1:0] SCR_on_EN = '0;
    logic       reset_IGBT_driver1 = 1'b0;
    logic       reset_IGBT_driver2 = 1'b0;
    logic       reset_IGBT_driver3 = 1'b0;
    logic [2:0] drv_fault_n = 3'b111;
    logic [4:0] igbt_gate;
    logic [1:0] scr_gate;
    logic [4:0] IGBT_status;
    logic [1:0] SCR_status;
    logic       fault_IGBT_driver1, fault_IGBT_driver2, fault_IGBT_driver3;
    logic       error_IGBT_driver1, error_IGBT_driver2, error_IGBT_driver3;

    int n_checks = 0;
    int n_errors = 0;

    gate_drive_if #(
        .DEAD_CYC     (DEAD),
        .MAX_ON_CYC   (MAXON),
        .FLT_FILT_CYC (FLT),
        .SCR_HI_CYC   (HI),
        .SCR_LO_CYC   (LO)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .IGBT_on_EN         (IGBT_on_EN),
        .SCR_on_EN          (SCR_on_EN),
        .reset_IGBT_driver1 (reset_IGBT_driver1),
        .reset_IGBT_driver2 (reset_IGBT_driver2),
        .reset_IGBT_driver3 (reset_IGBT_driver3),
        .drv_fault_n        (drv_fault_n),
        .igbt_gate          (igbt_gate),
        .scr_gate           (scr_gate),
        .IGBT_status        (IGBT_status),
        .SCR_status         (SCR_status),
        .fault_IGBT_driver1 (fault_IGBT_driver1),
        .fault_IGBT_driver2 (fault_IGBT_driver2),
        .fault_IGBT_driver3 (fault_IGBT_driver3),
        .error_IGBT_driver1 (error_IGBT_driver1),
        .error_IGBT_driver2 (error_IGBT_driver2),
        .error_IGBT_driver3 (error_IGBT_driver3)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state, all expressed as flags and elapsed-cycle counts.
    bit m_gate  [5];
    bit m_lock  [5];
    int m_quiet [5];  // consecutive partner-low cycles while waiting; -1 = not waiting
    int m_high  [5];  // cycles the gate has been high so far
    bit m_err   [3];
    bit m_flt   [3];
    int m_lowrun[3];
    bit m_s1    [3];
    bit m_s2    [3];
    bit m_act   [2];
    bit m_sgate [2];
    bit m_enp   [2];
    int m_start [2];
    int m_now;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int partner(input int i);
        if (i == 4) return -1;
        return i ^ 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_gate[i] = 0; m_lock[i] = 0; m_quiet[i] = -1; m_high[i] = 0;
        end
        for (int b = 0; b < 3; b++) begin
            m_err[b] = 0; m_flt[b] = 0; m_lowrun[b] = 0; m_s1[b] = 1; m_s2[b] = 1;
        end
        for (int s = 0; s < 2; s++) begin
            m_act[s] = 0; m_sgate[s] = 0; m_enp[s] = 0; m_start[s] = 0;
        end
        m_now = 0;
    endtask

    task automatic model_edge();
        bit g_old [5];
        bit blk [3];
        bit s2_old [3];
        bit req [3];
        req[0] = reset_IGBT_driver1; req[1] = reset_IGBT_driver2; req[2] = reset_IGBT_driver3;
        g_old = m_gate;
        s2_old = m_s2;
        for (int b = 0; b < 3; b++) blk[b] = m_flt[b] | m_err[b];

        for (int i = 0; i < 5; i++) begin
            bit e, b, p;
            e = IGBT_on_EN[i];
            b = blk[i / 2];
            p = (partner(i) >= 0) ? g_old[partner(i)] : 1'b0;
            if (m_gate[i]) begin
                if (!e) m_gate[i] = 0;
                else if (b || m_high[i] >= MAXON) begin m_gate[i] = 0; m_lock[i] = 1; end
                else m_high[i]++;
            end else if (m_lock[i]) begin
                if (!e) m_lock[i] = 0;
            end else if (m_quiet[i] >= 0) begin
                if (!e) m_quiet[i] = -1;
                else if (b) begin m_quiet[i] = -1; m_lock[i] = 1; end
                else if (p) m_quiet[i] = 0;
                else if (m_quiet[i] + 1 >= DEAD) begin
                    m_quiet[i] = -1; m_gate[i] = 1; m_high[i] = 1;
                end else m_quiet[i]++;
            end else if (e && !b) begin
                m_quiet[i] = 0;
            end
        end

        m_err[0] = IGBT_on_EN[0] & IGBT_on_EN[1];
        m_err[1] = IGBT_on_EN[2] & IGBT_on_EN[3];
        m_err[2] = 0;

        for (int b = 0; b < 3; b++) begin
            if (!s2_old[b]) begin
                m_lowrun[b]++;
                if (m_lowrun[b] >= FLT) m_flt[b] = 1;
            end else begin
                m_lowrun[b] = 0;
                if (req[b]) m_flt[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = drv_fault_n[b];
        end

        // SCR train: position inside the repeating HI+LO period since the train started.
        for (int s = 0; s < 2; s++) begin
            bit e;
            int k;
            e = SCR_on_EN[s];
            if (!m_act[s]) begin
                if (e && !m_enp[s]) begin
                    m_act[s] = 1; m_start[s] = m_now; m_sgate[s] = 1;
                end
            end else begin
                k = m_now - m_start[s];
                if (((k - 1) % PER) >= HI && !e) begin
                    m_act[s] = 0; m_sgate[s] = 0;
                end else begin
                    m_sgate[s] = ((k % PER) < HI);
                end
            end
            m_enp[s] = e;
        end
        m_now++;
    endtask

    task automatic compare_all();
        logic [4:0] eg;
        logic [1:0] esg, ess;
        logic [2:0] ef, ee;
        for (int i = 0; i < 5; i++) eg[i] = m_gate[i];
        for (int s = 0; s < 2; s++) begin esg[s] = m_sgate[s]; ess[s] = m_act[s]; end
        for (int b = 0; b < 3; b++) begin ef[b] = m_flt[b]; ee[b] = m_err[b]; end
        check("igbt_gate", 8'(igbt_gate), 8'(eg));
        check("igbt_status", 8'(IGBT_status), 8'(eg));
        check("scr_gate", 8'(scr_gate), 8'(esg));
        check("scr_status", 8'(SCR_status), 8'(ess));
        check("fault", 8'({fault_IGBT_driver3, fault_IGBT_driver2, fault_IGBT_driver1}), 8'(ef));
        check("error", 8'({error_IGBT_driver3, error_IGBT_driver2, error_IGBT_driver1}), 8'(ee));
        check("shoot_through",
              8'((igbt_gate[0] & igbt_gate[1]) | (igbt_gate[2] & igbt_gate[3])), 8'd0);
    endtask

    task automatic step();
        @(posedge sys_clk);
        if (!sys_rst_n) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic clear_inputs();
        IGBT_on_EN = '0; SCR_on_EN = '0; drv_fault_n = 3'b111;
        reset_IGBT_driver1 = 0; reset_IGBT_driver2 = 0; reset_IGBT_driver3 = 0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        run(2);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        model_reset();
        clear_inputs();
        do_reset();
        check("rst_gate", 8'(igbt_gate), 8'd0);
        check("rst_scr", 8'(scr_gate), 8'd0);
        run(2);

        // Dead-time latency and 1-cycle turn-off.
        IGBT_on_EN = 5'b00001;
        run(100);
        check("t1_before", 8'(igbt_gate[0]), 8'd0);
        run(1);
        check("t1_rise", 8'(igbt_gate[0]), 8'd1);
        check("t1_status", 8'(IGBT_status[0]), 8'd1);
        run(20);
        IGBT_on_EN = 5'b00000;
        run(1);
        check("t1_fall", 8'(igbt_gate[0]), 8'd0);
        run(5);

        // Both enables of board1: error pulse, both locked, IGBT1 held in lock.
        IGBT_on_EN = 5'b00001;
        run(120);
        IGBT_on_EN = 5'b00011;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin step(); if (error_IGBT_driver1) cnt++; end
        IGBT_on_EN = 5'b00010;
        for (int c = 0; c < 150; c++) begin step(); if (error_IGBT_driver1) cnt++; end
        check("t2_err_len", 8'(cnt), 8'd10);
        check("t2_lock1", 8'(igbt_gate[1]), 8'd0);
        IGBT_on_EN = 5'b00000;
        run(3);

        // Fault filter boundary, ignored clear while faulted, clear after release.
        IGBT_on_EN = 5'b00100;
        run(120);
        drv_fault_n = 3'b101;
        run(24);
        drv_fault_n = 3'b111;
        run(6);
        check("t3_flt24", 8'(fault_IGBT_driver2), 8'd0);
        check("t3_gate_on", 8'(igbt_gate[2]), 8'd1);
        drv_fault_n = 3'b101;
        run(30);
        check("t3_flt25", 8'(fault_IGBT_driver2), 8'd1);
        check("t3_gate_off", 8'(igbt_gate[3:2]), 8'd0);
        reset_IGBT_driver2 = 1;
        run(3);
        check("t3_rst_ignored", 8'(fault_IGBT_driver2), 8'd1);
        drv_fault_n = 3'b111;
        run(4);
        reset_IGBT_driver2 = 0;
        run(1);
        check("t3_cleared", 8'(fault_IGBT_driver2), 8'd0);
        run(150);
        check("t3_still_lock", 8'(igbt_gate[2]), 8'd0);
        IGBT_on_EN = 5'b00000;
        run(3);

        // Watchdog on the unpartnered channel, then relaunch after en cycling.
        IGBT_on_EN = 5'b10000;
        cnt = 0;
        for (int c = 0; c < 1300; c++) begin step(); if (igbt_gate[4]) cnt++; end
        check("t4_on_len", 8'(cnt / 8), 8'(MAXON / 8));
        check("t4_on_len_lsb", 8'(cnt % 8), 8'(MAXON % 8));
        check("t4_locked", 8'(igbt_gate[4]), 8'd0);
        IGBT_on_EN = 5'b00000;
        run(1);
        IGBT_on_EN = 5'b10000;
        run(101);
        check("t4_relaunch", 8'(igbt_gate[4]), 8'd1);
        IGBT_on_EN = 5'b00000;
        run(3);

        // SCR: en dropped inside the first LO gap, then a 4000-cycle hold.
        SCR_on_EN = 2'b01;
        cnt = 0;
        for (int c = 0; c < 1800; c++) begin step(); if (scr_gate[0]) cnt++; end
        check("t5_hi_len", 8'(cnt / 4), 8'(HI / 4));
        SCR_on_EN = 2'b00;
        run(1);
        check("t5_idle", 8'(SCR_status[0]), 8'd0);
        run(5);
        SCR_on_EN = 2'b01;
        cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            logic prev;
            prev = scr_gate[0];
            step();
            if (scr_gate[0] && !prev) cnt++;
        end
        check("t5_pulses", 8'(cnt), 8'd2);
        SCR_on_EN = 2'b00;
        run(3);

        // Randomised segments.
        for (int seg = 0; seg < 60; seg++) begin
            logic [4:0] en;
            int r;
            en = '0;
            for (int b = 0; b < 2; b++) begin
                r = $urandom_range(0, 9);
                if (r >= 3 && r <= 5) en[2*b] = 1'b1;
                else if (r >= 6 && r <= 8) en[2*b+1] = 1'b1;
                else if (r == 9) begin en[2*b] = 1'b1; en[2*b+1] = 1'b1; end
            end
            en[4] = 1'($urandom_range(0, 1));
            IGBT_on_EN = en;
            SCR_on_EN = 2'($urandom_range(0, 3));
            for (int b = 0; b < 3; b++) drv_fault_n[b] = ($urandom_range(0, 7) != 0);
            reset_IGBT_driver1 = ($urandom_range(0, 2) == 0);
            reset_IGBT_driver2 = ($urandom_range(0, 2) == 0);
            reset_IGBT_driver3 = ($urandom_range(0, 2) == 0);
            run($urandom_range(1, 400));
        end

        // Asynchronous reset while IGBT2 and SCR1 are both driving.
        clear_inputs();
        do_reset();
        run(2);
        IGBT_on_EN = 5'b00100;
        SCR_on_EN = 2'b10;
        run(150);
        check("t6_gate2_pre", 8'(igbt_gate[2]), 8'd1);
        check("t6_scr1_pre", 8'(scr_gate[1]), 8'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_gate_async", 8'(igbt_gate), 8'd0);
        check("t6_scr_async", 8'(scr_gate), 8'd0);
        compare_all();
        run(2);
        sys_rst_n = 1'b1;
        run(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
